multiword_add_seq: RTL and testbench



---
 rtl/adder_pkg.sv | 28 ++
 rtl/ripple_carry_adder_16bit.sv | 31 +++
 rtl/multiword_add_seq.sv | 125 ++++++++++++
 tb/tb_multiword_add_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for the sequential multi-word adder:
//               slice width, FSM state encoding and a word-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam int WORD_W = 16;
  // Widest operand supported (16 slices of 16 bits); the word-select helper
  // works on vectors zero-extended to this width.
  localparam int MAX_W  = 16 * WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Return 16-bit word k of a (zero-extended) operand vector.
  function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_W-1:0] v,
                                                  input logic [31:0]      k);
    return v[k*WORD_W +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder_16bit
// Description : Purely combinational 16-bit ripple-carry adder.
// Ports       : a_i, b_i  - 16-bit addends
//               cin_i     - carry in
//               sum_o     - 16-bit sum
//               cout_o    - carry out of bit 15
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [16:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[16];

endmodule
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_seq
// Description : Sequential multi-word adder. Accepts 16*NWORDS-bit operands
//               on a valid/ready handshake, adds one 16-bit slice per cycle
//               through a single ripple adder with the carry held in a
//               register, and presents the sum/carry on a held valid/ready
//               output.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid/in_ready          - operand handshake
//               in_a, in_b, in_cin         - operands and carry in
//               out_valid/out_ready        - result handshake
//               out_sum, out_cout          - registered result
//               busy                       - operation in progress or held
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] in_a,
  input  logic [WORD_W*NWORDS-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int W    = WORD_W * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  add_state_t        state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [IDXW-1:0]   idx_q;

  logic [MAX_W-1:0]  a_ext;
  logic [MAX_W-1:0]  b_ext;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  // Zero-extend so the shared word-select helper is width-independent.
  always_comb begin
    a_ext          = '0;
    b_ext          = '0;
    a_ext[W-1:0]   = a_q;
    b_ext[W-1:0]   = b_q;
  end

  assign add_a = word_sel(a_ext, 32'(idx_q));
  assign add_b = word_sel(b_ext, 32'(idx_q));

  ripple_carry_adder_16bit u_rca (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[32'(idx_q)*WORD_W +: WORD_W] <= add_sum;
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            // Hold idx on the last slice so it never runs past NWORDS-1.
            cout_q  <= add_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_add_seq
// Description : Self-checking bench for multiword_add_seq (NWORDS=4 and 1)
//               with a scoreboard queue of expected {cout, sum} values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid,  in_ready,  in_cin,  out_valid,  out_ready,  out_cout,  busy;
  logic [63:0] in_a, in_b, out_sum;

  logic        d1_in_valid, d1_in_ready, d1_in_cin, d1_out_valid, d1_out_ready, d1_out_cout, d1_busy;
  logic [15:0] d1_in_a, d1_in_b, d1_out_sum;

  int errors;
  int checks;

  logic [64:0] sb4[$];
  logic [16:0] sb1[$];

  multiword_add_seq #(.NWORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  multiword_add_seq #(.NWORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_a(d1_in_a), .in_b(d1_in_b), .in_cin(d1_in_cin),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_sum(d1_out_sum), .out_cout(d1_out_cout), .busy(d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the reference result and present the operands for one accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_ready: got %b want 1", in_ready);
    end
    sb4.push_back({1'b0, a} + {1'b0, b} + {64'd0, cin});
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: out_valid never rose within %0d cycles", cycles);
    end
  endtask

  task automatic check_result(input string name);
    logic [64:0] exp;
    checks++;
    if (sb4.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp = sb4.pop_front();
      if ({out_cout, out_sum} !== exp) begin
        errors++;
        $display("FAIL %s: got cout=%b sum=%h want cout=%b sum=%h", name, out_cout, out_sum, exp[64], exp[63:0]);
      end
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input string name);
    int cyc;
    start_op(a, b, cin);
    wait_valid(cyc);
    check_result(name);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b sum=%h cout=%b want 0", out_valid, busy, out_sum, out_cout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || d1_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, d1_in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_valid(cyc);
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL latency4: got %0d cycles want 4", cyc);
    end
    check_result("carry_ripple");
    tick();
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, "directed_sum");
    t0 = $time;
    for (int i = 0; i < 6; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "random_sum");
    end
    t1 = $time;
    checks++;
    if (t1 - t0 != 6 * 6 * 10) begin
      errors++;
      $display("FAIL issue_interval: got %0d ns for 6 ops want %0d", t1 - t0, 360);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [63:0] s;
    logic c;
    out_ready = 1'b0;
    start_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_valid(cyc);
    check_result("bp_sum");
    s = out_sum; c = out_cout;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s || out_cout !== c) begin
        errors++;
        $display("FAIL bp_hold: valid=%b ready=%b sum=%h cout=%b want 1 0 %h %b", out_valid, in_ready, out_sum, out_cout, s, c);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    start_op(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0);
    tick();
    tick();
    checks++;
    if (out_sum === 64'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_partial: sum=%h busy=%b want nonzero 1", out_sum, busy);
    end
    void'(sb4.pop_front());
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b sum=%h cout=%b busy=%b want 0", out_valid, out_sum, out_cout, busy);
    end
    #4;
    rst_n = 1'b1;
    tick();
    run_op(64'd5, 64'd7, 1'b0, "after_reset_sum");
  endtask

  task automatic test_ignore_busy();
    int cyc;
    start_op(64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b0);
    in_a = 64'hAAAA_AAAA_AAAA_AAAA; in_b = 64'hAAAA_AAAA_AAAA_AAAA; in_valid = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_ready: got %b want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    wait_valid(cyc);
    check_result("ignore_busy");
    tick();
  endtask

  task automatic test_nwords1();
    int cyc;
    logic [16:0] exp;
    sb1.push_back({1'b0, 16'h8000} + {1'b0, 16'h8000});
    d1_in_a = 16'h8000; d1_in_b = 16'h8000; d1_in_cin = 1'b0; d1_in_valid = 1'b1;
    tick();
    d1_in_valid = 1'b0;
    cyc = 0;
    while (d1_out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL latency1: got %0d cycles want 1", cyc);
    end
    exp = sb1.pop_front();
    checks++;
    if ({d1_out_cout, d1_out_sum} !== exp) begin
      errors++;
      $display("FAIL nwords1_sum: got cout=%b sum=%h want cout=%b sum=%h", d1_out_cout, d1_out_sum, exp[16], exp[15:0]);
    end
    tick();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_in_a = '0; d1_in_b = '0; d1_in_cin = 1'b0; d1_out_ready = 1'b1;
    #3;
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_ignore_busy();
    test_nwords1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
